// File: rtl/csr_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : csr_irq_ctrl
//  Purpose  : CSR-mapped interrupt controller. Latches edge/level requests
//             from COUNT sources, masks them with an enable register and
//             drives one registered irq to the core. Fixed priority (lowest
//             index wins) with a claim/complete handshake through CSRs.
//             CSR map: BASE_ADDR = PENDING, +1 = ENABLE, +2 = CLAIM.
//  Options  : CSR_IRQ_CTRL_SWTRIG_EN - set on PENDING triggers edge sources
//             from software.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_irq_ctrl #(
    parameter logic [11:0]      BASE_ADDR = 12'hbc4,
    parameter int               COUNT     = 8,
    parameter logic [COUNT-1:0] EDGE_MASK = {COUNT{1'b0}}
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             read,
    input  logic [2:0]       modify,
    input  logic [31:0]      wdata,
    input  logic [11:0]      addr,
    output logic [31:0]      rdata,
    output logic             valid,
    input  logic [COUNT-1:0] src,
    output logic             irq,
    output logic             AVOID_WARNING
);

    localparam logic [11:0] ADDR_PEND  = BASE_ADDR;
    localparam logic [11:0] ADDR_EN    = BASE_ADDR + 12'd1;
    localparam logic [11:0] ADDR_CLAIM = BASE_ADDR + 12'd2;

    localparam logic [2:0]  MOD_WRITE  = 3'b001;
    localparam logic [2:0]  MOD_SET    = 3'b010;
    localparam logic [2:0]  MOD_CLEAR  = 3'b011;

    // Registered address decode
    logic q_en_pend;
    logic q_en_en;
    logic q_en_claim;

    // Source history and controller state
    logic [COUNT-1:0] q_src_prev;
    logic [COUNT-1:0] pending;
    logic [COUNT-1:0] enable;
    logic [COUNT-1:0] inservice;

    // Combinational helpers
    logic [COUNT-1:0] edges;
    logic [COUNT-1:0] active;
    logic [COUNT-1:0] claim_onehot;
    logic [4:0]       claim_idx;
    logic             claim_hit;
    logic             claim_take;
    logic [COUNT-1:0] complete_mask;
    logic [COUNT-1:0] pend_clr;
    logic [COUNT-1:0] sw_set;
    logic [COUNT-1:0] pending_next;
    logic [COUNT-1:0] inservice_next;
    logic [COUNT-1:0] enable_next;

    assign edges  = src & ~q_src_prev & EDGE_MASK;
    assign active = pending & enable & ~inservice;

    // Address decode registered one cycle ahead of the data phase
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_en_pend  <= 1'b0;
            q_en_en    <= 1'b0;
            q_en_claim <= 1'b0;
        end else begin
            q_en_pend  <= (addr == ADDR_PEND);
            q_en_en    <= (addr == ADDR_EN);
            q_en_claim <= (addr == ADDR_CLAIM);
        end
    end

    // Priority pick: lowest-index active source
    always_comb begin
        claim_onehot = '0;
        claim_idx    = 5'd0;
        claim_hit    = 1'b0;
        for (int i = 0; i < COUNT; i++) begin
            if (active[i] && !claim_hit) begin
                claim_hit       = 1'b1;
                claim_onehot[i] = 1'b1;
                claim_idx       = 5'(i);
            end
        end
    end

    assign claim_take = q_en_claim & read & claim_hit;

    // Complete decode: wdata is a 1-based source id, out-of-range ids match nothing
    always_comb begin
        complete_mask = '0;
        if (q_en_claim && (modify == MOD_WRITE)) begin
            for (int i = 0; i < COUNT; i++) begin
                if (wdata == 32'(i + 1)) begin
                    complete_mask[i] = 1'b1;
                end
            end
        end
    end

    // Software clear only reaches edge-triggered bits
    assign pend_clr = (q_en_pend && (modify == MOD_CLEAR)) ?
                      (wdata[COUNT-1:0] & EDGE_MASK) : '0;

`ifdef CSR_IRQ_CTRL_SWTRIG_EN
    // Software trigger on edge sources, merged with hardware edges
    assign sw_set = (q_en_pend && (modify == MOD_SET)) ?
                    (wdata[COUNT-1:0] & EDGE_MASK) : '0;
`else
    assign sw_set = '0;
`endif

    // Next pending: edge bits keep/clear/set (new edge wins), level bits follow src
    always_comb begin
        pending_next = pending & ~pend_clr;
        if (claim_take) begin
            pending_next = pending_next & ~claim_onehot;
        end
        pending_next = ((pending_next | edges | sw_set) & EDGE_MASK) | (src & ~EDGE_MASK);
    end

    // Next in-service: complete clears first, claim set wins on the same source
    always_comb begin
        inservice_next = inservice & ~complete_mask;
        if (claim_take) begin
            inservice_next = inservice_next | claim_onehot;
        end
    end

    // Next enable: write/set/clear on the low COUNT bits
    always_comb begin
        enable_next = enable;
        if (q_en_en) begin
            case (modify)
                MOD_WRITE: enable_next = wdata[COUNT-1:0];
                MOD_SET:   enable_next = enable | wdata[COUNT-1:0];
                MOD_CLEAR: enable_next = enable & ~wdata[COUNT-1:0];
                default:   enable_next = enable;
            endcase
        end
    end

    // Controller state registers and registered irq
    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_src_prev <= '0;
            pending    <= '0;
            enable     <= '0;
            inservice  <= '0;
            irq        <= 1'b0;
        end else begin
            q_src_prev <= src;
            pending    <= pending_next;
            enable     <= enable_next;
            inservice  <= inservice_next;
            irq        <= |active;
        end
    end

    // CSR read mux, zero when this block is not addressed
    always_comb begin
        rdata = 32'd0;
        if (q_en_pend) begin
            rdata[COUNT-1:0] = pending;
        end else if (q_en_en) begin
            rdata[COUNT-1:0] = enable;
        end else if (q_en_claim) begin
            if (read) begin
                rdata = claim_hit ? ({27'd0, claim_idx} + 32'd1) : 32'd0;
            end else begin
                rdata[31] = |inservice;
            end
        end
    end

    assign valid         = q_en_pend | q_en_en | q_en_claim;
    assign AVOID_WARNING = |wdata[31:COUNT];

endmodule
`default_nettype wire

// File: tb/tb_csr_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_csr_irq_ctrl
//  Purpose  : directed self-checking bench for csr_irq_ctrl (COUNT=8,
//             EDGE_MASK=8'h01: source 0 edge, the rest level).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_csr_irq_ctrl;

    localparam logic [11:0] BASE = 12'hbc4;
    localparam logic [11:0] A_PEND  = BASE;
    localparam logic [11:0] A_EN    = BASE + 12'd1;
    localparam logic [11:0] A_CLAIM = BASE + 12'd2;
    localparam logic [11:0] A_IDLE  = 12'h000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        read;
    logic [2:0]  modify;
    logic [31:0] wdata;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic        valid;
    logic [7:0]  src;
    logic        irq;
    logic        avoid_warning;

    int total = 0;
    int bad   = 0;

    logic [31:0] rv;
    logic        vv;

    csr_irq_ctrl #(
        .BASE_ADDR (BASE),
        .COUNT     (8),
        .EDGE_MASK (8'h01)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .read          (read),
        .modify        (modify),
        .wdata         (wdata),
        .addr          (addr),
        .rdata         (rdata),
        .valid         (valid),
        .src           (src),
        .irq           (irq),
        .AVOID_WARNING (avoid_warning)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CSR access: address cycle, then data cycle; e0 raises src[0] in the data cycle
    task automatic csr(input logic [11:0] a, input logic rd, input logic [2:0] md,
                       input logic [31:0] wd, input logic e0,
                       output logic [31:0] r, output logic v);
        addr = a;
        tick();
        addr   = A_IDLE;
        read   = rd;
        modify = md;
        wdata  = wd;
        if (e0) src[0] = 1'b1;
        #3;
        r = rdata;
        v = valid;
        tick();
        read   = 1'b0;
        modify = 3'b000;
        wdata  = 32'd0;
        if (e0) src[0] = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
        logic [31:0] r;
        logic        v;
        csr(a, 1'b1, 3'b000, 32'd0, 1'b0, r, v);
        check(tag, r, exp);
    endtask

    task automatic wr(input logic [11:0] a, input logic [2:0] md, input logic [31:0] wd);
        logic [31:0] r;
        logic        v;
        csr(a, 1'b0, md, wd, 1'b0, r, v);
    endtask

    initial begin
        rstn = 1'b0; read = 1'b0; modify = 3'b000; wdata = 32'd0;
        addr = A_IDLE; src = 8'h00;
        repeat (3) tick();
        rstn = 1'b1;
        #3;
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);

        // Reset state reads and address decode
        csr(A_PEND, 1'b1, 3'b000, 32'd0, 1'b0, rv, vv);
        check("pend_reset", rv, 32'd0);
        check("pend_valid", {31'd0, vv}, 32'd1);
        csr(A_EN, 1'b1, 3'b000, 32'd0, 1'b0, rv, vv);
        check("en_reset", rv, 32'd0);
        check("en_valid", {31'd0, vv}, 32'd1);
        csr(A_CLAIM, 1'b1, 3'b000, 32'd0, 1'b0, rv, vv);
        check("claim_reset", rv, 32'd0);
        check("claim_valid", {31'd0, vv}, 32'd1);
        csr(BASE + 12'd3, 1'b1, 3'b000, 32'd0, 1'b0, rv, vv);
        check("other_valid", {31'd0, vv}, 32'd0);
        check("other_rdata", rv, 32'd0);

        // Disabled edge source still latches; enable raises irq two cycles later
        src[0] = 1'b1; tick(); src[0] = 1'b0; tick(); tick();
        rd_chk("pend_edge_disabled", A_PEND, 32'h1);
        check("irq_disabled", {31'd0, irq}, 32'd0);
        wr(A_EN, 3'b001, 32'h1);
        check("irq_en_plus1", {31'd0, irq}, 32'd0);
        tick();
        check("irq_en_plus2", {31'd0, irq}, 32'd1);

        // Claim edge source 0, then complete it
        rd_chk("claim_src0", A_CLAIM, 32'd1);
        check("irq_after_claim_1", {31'd0, irq}, 32'd1);
        tick();
        check("irq_after_claim_2", {31'd0, irq}, 32'd0);
        rd_chk("pend_after_claim", A_PEND, 32'h0);
        csr(A_CLAIM, 1'b0, 3'b000, 32'd0, 1'b0, rv, vv);
        check("claim_status_busy", rv, 32'h8000_0000);
        wr(A_CLAIM, 3'b001, 32'd1);
        csr(A_CLAIM, 1'b0, 3'b000, 32'd0, 1'b0, rv, vv);
        check("claim_status_idle", rv, 32'h0);

        // Level sources 3 and 5 with priority and re-assertion after complete
        wr(A_EN, 3'b001, 32'hff);
        src[3] = 1'b1; src[5] = 1'b1;
        tick();
        check("irq_lvl_plus1", {31'd0, irq}, 32'd0);
        tick();
        check("irq_lvl_plus2", {31'd0, irq}, 32'd1);
        rd_chk("claim_lvl3", A_CLAIM, 32'd4);
        tick();
        check("irq_lvl5_still", {31'd0, irq}, 32'd1);
        rd_chk("claim_lvl5", A_CLAIM, 32'd6);
        tick();
        check("irq_all_claimed", {31'd0, irq}, 32'd0);
        rd_chk("pend_lvl", A_PEND, 32'h28);
        wr(A_PEND, 3'b011, 32'hff);
        rd_chk("pend_lvl_noclear", A_PEND, 32'h28);
        wr(A_CLAIM, 3'b001, 32'd0);
        wr(A_CLAIM, 3'b001, 32'd9);
        wr(A_CLAIM, 3'b001, 32'd2);
        rd_chk("claim_none_after_bad_cpl", A_CLAIM, 32'd0);
        check("irq_after_bad_cpl", {31'd0, irq}, 32'd0);
        wr(A_CLAIM, 3'b001, 32'd4);
        check("irq_cpl_plus1", {31'd0, irq}, 32'd0);
        tick();
        check("irq_cpl_plus2", {31'd0, irq}, 32'd1);
        rd_chk("claim_lvl3_again", A_CLAIM, 32'd4);
        src[3] = 1'b0; src[5] = 1'b0;
        tick(); tick();
        wr(A_CLAIM, 3'b001, 32'd4);
        wr(A_CLAIM, 3'b001, 32'd6);
        tick(); tick();
        check("irq_lvl_done", {31'd0, irq}, 32'd0);
        csr(A_CLAIM, 1'b0, 3'b000, 32'd0, 1'b0, rv, vv);
        check("claim_status_clear", rv, 32'h0);

        // Claim racing a new edge on the same source
        src[0] = 1'b1; tick(); src[0] = 1'b0; tick();
        csr(A_CLAIM, 1'b1, 3'b000, 32'd0, 1'b1, rv, vv);
        check("claim_race", rv, 32'd1);
        rd_chk("pend_race_kept", A_PEND, 32'h1);
        csr(A_CLAIM, 1'b0, 3'b000, 32'd0, 1'b0, rv, vv);
        check("claim_race_busy", rv, 32'h8000_0000);
        check("irq_race_masked", {31'd0, irq}, 32'd0);
        wr(A_CLAIM, 3'b001, 32'd1);
        wr(A_PEND, 3'b011, 32'hff);
        rd_chk("pend_edge_cleared", A_PEND, 32'h0);
        rd_chk("claim_empty", A_CLAIM, 32'd0);

        // Software trigger on edge source 0
        wr(A_PEND, 3'b010, 32'h1);
`ifdef CSR_IRQ_CTRL_SWTRIG_EN
        check("irq_sw_plus1", {31'd0, irq}, 32'd0);
        tick();
        check("irq_sw_plus2", {31'd0, irq}, 32'd1);
        rd_chk("claim_sw", A_CLAIM, 32'd1);
        wr(A_CLAIM, 3'b001, 32'd1);
`else
        tick();
        check("irq_sw_off", {31'd0, irq}, 32'd0);
        rd_chk("pend_sw_off", A_PEND, 32'h0);
`endif

        // Enable clear/set; upper wdata bits ignored
        wr(A_EN, 3'b011, 32'hfe);
        rd_chk("en_clear", A_EN, 32'h01);
        wr(A_EN, 3'b010, 32'h0000_0102);
        rd_chk("en_set", A_EN, 32'h03);

        // Reset while a source is in service
        wr(A_EN, 3'b001, 32'hff);
        src[3] = 1'b1;
        tick(); tick();
        rd_chk("claim_before_rst", A_CLAIM, 32'd4);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        #3;
        check("irq_after_rst", {31'd0, irq}, 32'd0);
        tick();
        src[3] = 1'b0;
        csr(A_CLAIM, 1'b0, 3'b000, 32'd0, 1'b0, rv, vv);
        check("claim_status_rst", rv, 32'h0);
        rd_chk("en_after_rst", A_EN, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
